reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
Tracks in-flight writes to the CPU register file: R0-R7, T, SP, IH and RA.
- Each architectural register has a saturating pending-write counter.
- The decode stage is stalled on RAW hazards and on counter saturation.
- A drain handshake lets the interrupt/exception logic wait until every outstanding writeback has retired before it touches IH/RA.
- Sits between decode/issue and writeback, beside the register file.

Parameters:
CNT_W, 2, width of each pending counter; maximum outstanding writes per register = 2^CNT_W-1
STALL_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
flush  in  1  synchronous clear of all pending counters (pipeline flush)
issue_valid  in  1  decode presents an instruction
issue_src_a  in  4  register code of source A (see encoding)
issue_src_b  in  4  register code of source B
issue_dst  in  4  register code of destination
issue_ready  out  1  combinational: instruction may issue this cycle
wb_valid  in  1  writeback retires a write this cycle
wb_dst  in  4  register code being written back
drain_req  in  1  request to quiesce issue and wait for all writes to retire
drained  out  1  registered: drain complete, no pending writes
busy  out  12  per-register pending flag (counter != 0); bit index = register code
stall_cnt  out  STALL_W  saturating count of stalled issue cycles
err_underflow  out  1  sticky: a retire targeted a register with counter 0

Behaviour:
- Register code encoding: 0-7 = R0-R7; 8 = T; 9 = SP; 10 = IH; 11 = RA; 12-15 = none.
  - "None" never hazards, is never counted, and is ignored on retire.
- Reset (rst=0, async): all counters 0, FSM=RUN, drained=0, stall_cnt=0, err_underflow=0, so busy=0.
- Hazard check (combinational): a source with pending counter != 0 blocks issue.
- WAW check: a destination counter at 2^CNT_W-1 blocks issue.
- issue_ready = (FSM==RUN) && no src hazard && dst not saturated && !flush.
- Issue accepted when issue_valid && issue_ready; dst counter +1, visible next cycle.
- Retire when wb_valid && wb_dst<12: counter -1 next cycle.
  - If that counter is already 0: no change, err_underflow<=1.
  - err_underflow clears only on reset.
- Same-cycle issue and retire on the same register: net counter change 0.
- flush=1: all counters <=0 next cycle, regardless of any issue or retire that cycle. No underflow error is raised that cycle.
- stall_cnt: +1 on each cycle with issue_valid && !issue_ready; saturates at all-ones.
- FSM:
  - RUN: on drain_req go to DRAIN.
  - DRAIN: issue_ready=0. When all counters are 0 (or on flush) go to DRAINED.
  - DRAINED: drained=1 and issue_ready=0. When drain_req falls go to RUN.
  - drained is 0 in every other state.
  - If drain_req drops while in DRAIN, go back to RUN.
- Cycle-level example: drain_req asserted with one write pending.
  - Next cycle: DRAIN.
  - Retire cycle: counter hits 0.
  - Following cycle: DRAINED, drained=1.

Optional Feature:
SB_BYPASS_EN, when defined, adds writeback bypass:
- A source whose counter is 1 and which is being retired this same cycle is treated as ready.
- A saturated destination that is being retired this cycle is treated as not saturated.

Without the macro, both cases stall one extra cycle until the counter update is visible.

Decomposition:
- Shared package:
  - register-code constants: REG_CODE_T, REG_CODE_SP, REG_CODE_IH, REG_CODE_RA, REG_CODE_NONE
  - REG_CODE_NUM=12
  - FSM state encodings: SB_RUN, SB_DRAIN, SB_DRAINED
- One sub-module, sb_counter: a single CNT_W-bit up/down saturating counter.
  - Inputs: inc, dec, clr.
  - Outputs: count, nonzero, full, underflow.
  - Instantiated 12 times by a generate loop.

Test Plan:
1. Issue dst=R3, then src_a=R3 next cycle -> issue_ready=0, stall_cnt=1; wb_dst=3 -> busy[3]=0 next cycle and issue proceeds. With SB_BYPASS_EN, the retire cycle itself gives issue_ready=1.
2. CNT_W=2: issue three writes to SP with no retire -> busy[9]=1; a fourth issue with dst=SP -> issue_ready=0; retire one -> issue accepted the following cycle.
3. Retire wb_dst=5 with counter 0 -> err_underflow=1 and stays 1; busy unchanged.
4. Two writes pending to R1, assert drain_req -> issue_ready=0 immediately after entering DRAIN. After both retires, drained=1 one cycle later. Drop drain_req -> RUN, drained=0.
5. Pending writes to R0, T and RA, then pulse flush -> busy=0 next cycle; a simultaneous issue in the flush cycle is not accepted (issue_ready=0).
6. Assert rst low asynchronously mid-drain with counters non-zero -> busy=0, drained=0, stall_cnt=0, err_underflow=0 without waiting for a clock edge; FSM returns to RUN.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard: register codes and FSM states.
package reg_scoreboard_pkg;

  localparam logic [3:0] REG_CODE_T    = 4'd8;
  localparam logic [3:0] REG_CODE_SP   = 4'd9;
  localparam logic [3:0] REG_CODE_IH   = 4'd10;
  localparam logic [3:0] REG_CODE_RA   = 4'd11;
  localparam logic [3:0] REG_CODE_NONE = 4'd12;
  localparam int         REG_CODE_NUM  = 12;

  typedef enum logic [1:0] {
    SB_RUN     = 2'd0,
    SB_DRAIN   = 2'd1,
    SB_DRAINED = 2'd2
  } sb_state_t;

  // Codes 12-15 all mean "no register".
  function automatic logic is_reg(input logic [3:0] code);
    return code < 4'(REG_CODE_NUM);
  endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one saturating up/down pending-write counter with sync clear.
// Underflow flags a decrement at zero; the count itself is left unchanged.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  logic inc_ok;
  logic dec_ok;

  assign nonzero   = (count != '0);
  assign full      = (count == '1);
  assign underflow = dec && !nonzero && !clr;

  // A full counter may still take an increment when it is retired the same cycle.
  assign inc_ok = inc && (!full || dec);
  assign dec_ok = dec && nonzero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      case ({inc_ok, dec_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: RAW/WAW issue gating, pending-write counters and drain handshake.
// Optional writeback bypass is enabled by defining SB_BYPASS_EN.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic [3:0]         issue_src_a,
  input  logic [3:0]         issue_src_b,
  input  logic [3:0]         issue_dst,
  output logic               issue_ready,
  input  logic               wb_valid,
  input  logic [3:0]         wb_dst,
  input  logic               drain_req,
  output logic               drained,
  output logic [11:0]        busy,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               err_underflow
);

`ifdef SB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  sb_state_t state;

  logic [CNT_W-1:0] cnt [REG_CODE_NUM];
  logic [11:0] full;
  logic [11:0] underflow;
  logic [11:0] one;
  logic [15:0] busy_x;
  logic [15:0] full_x;
  logic [15:0] retire_x;
  logic [15:0] inc_x;
  logic [15:0] src_clear;
  logic [15:0] dst_relief;
  logic        hazard_a;
  logic        hazard_b;
  logic        dst_sat;
  logic        issue_fire;

  // Padding to 16 entries lets the 4-bit codes index directly; "none" codes read as idle.
  assign busy_x   = {4'b0, busy};
  assign full_x   = {4'b0, full};
  assign retire_x = (wb_valid && is_reg(wb_dst)) ? (16'd1 << wb_dst) : 16'd0;

  assign src_clear  = {4'b0, one}  & retire_x & {16{BYPASS_EN}};
  assign dst_relief = full_x       & retire_x & {16{BYPASS_EN}};

  assign hazard_a = busy_x[issue_src_a] && !src_clear[issue_src_a];
  assign hazard_b = busy_x[issue_src_b] && !src_clear[issue_src_b];
  assign dst_sat  = full_x[issue_dst]   && !dst_relief[issue_dst];

  assign issue_ready = (state == SB_RUN) && !hazard_a && !hazard_b && !dst_sat && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign inc_x       = (issue_fire && is_reg(issue_dst)) ? (16'd1 << issue_dst) : 16'd0;

  for (genvar i = 0; i < REG_CODE_NUM; i++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_x[i]),
      .dec       (retire_x[i]),
      .clr       (flush),
      .count     (cnt[i]),
      .nonzero   (busy[i]),
      .full      (full[i]),
      .underflow (underflow[i])
    );
    assign one[i] = (cnt[i] == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underflow <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (|underflow)
        err_underflow <= 1'b1;
      if (issue_valid && !issue_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SB_RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        SB_RUN: begin
          drained <= 1'b0;
          if (drain_req)
            state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (!drain_req) begin
            state <= SB_RUN;
          end else if (!(|busy) || flush) begin
            state   <= SB_DRAINED;
            drained <= 1'b1;
          end
        end
        SB_DRAINED: begin
          if (!drain_req) begin
            state   <= SB_RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= SB_RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

endmodule
